// File: rtl/meta_sched_pkg.sv
// Shared types and default widths for the tag-array metadata write scheduler.
package meta_sched_pkg;

  localparam int unsigned IDX_W = 6;
  localparam int unsigned WAYS  = 4;
  localparam int unsigned TAG_W = 20;

  typedef struct packed {
    logic [IDX_W-1:0] idx;
    logic [WAYS-1:0]  way_en;
    logic [TAG_W-1:0] tag;
  } meta_write_t;

  typedef enum logic {
    SRC_P0 = 1'b0,
    SRC_P1 = 1'b1
  } src_t;

endpackage

// File: rtl/meta_write_fifo.sv
// Small circular FIFO for queued metadata writes; full FIFO is never ready,
// even while its head is being dequeued. Flush clears it synchronously.
module meta_write_fifo
  import meta_sched_pkg::*;
#(
  parameter int unsigned DEPTH = 2,
  parameter type         T     = meta_write_t
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic flush_i,
  input  logic enq_valid_i,
  output logic enq_ready_o,
  input  T     enq_data_i,
  input  logic deq_i,
  output T     deq_data_o,
  output logic empty_o,
  output logic full_o
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

  T                 mem_q [DEPTH];
  logic [PTR_W-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             enq, deq;

  assign full_o      = (cnt_q == CNT_W'(DEPTH));
  assign empty_o     = (cnt_q == '0);
  assign enq_ready_o = !full_o && !flush_i;
  assign enq         = enq_valid_i && enq_ready_o;
  assign deq         = deq_i && !empty_o && !flush_i;
  assign deq_data_o  = mem_q[rd_q];

  always_comb begin
    wr_d  = wr_q;
    rd_d  = rd_q;
    cnt_d = cnt_q;
    if (flush_i) begin
      wr_d  = '0;
      rd_d  = '0;
      cnt_d = '0;
    end else begin
      if (enq) wr_d = wr_q + PTR_W'(1);
      if (deq) rd_d = rd_q + PTR_W'(1);
      if (enq && !deq)      cnt_d = cnt_q + CNT_W'(1);
      else if (!enq && deq) cnt_d = cnt_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (enq) mem_q[wr_q] <= enq_data_i;
  end

endmodule

// File: rtl/meta_write_scheduler.sv
// Two-port metadata write scheduler: per-port FIFOs, port 0 priority, one
// registered output stage. META_SCHED_STARVE_GUARD_EN adds a port-1 starvation guard.
module meta_write_scheduler
  import meta_sched_pkg::*;
#(
  parameter int unsigned DEPTH        = 2,
  parameter int unsigned IDX_W        = meta_sched_pkg::IDX_W,
  parameter int unsigned WAYS         = meta_sched_pkg::WAYS,
  parameter int unsigned TAG_W        = meta_sched_pkg::TAG_W,
  parameter int unsigned STARVE_LIMIT = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             io_flush,
  input  logic             io_in_0_valid,
  output logic             io_in_0_ready,
  input  logic [IDX_W-1:0] io_in_0_bits_idx,
  input  logic [WAYS-1:0]  io_in_0_bits_way_en,
  input  logic [TAG_W-1:0] io_in_0_bits_tag,
  input  logic             io_in_1_valid,
  output logic             io_in_1_ready,
  input  logic [IDX_W-1:0] io_in_1_bits_idx,
  input  logic [WAYS-1:0]  io_in_1_bits_way_en,
  input  logic [TAG_W-1:0] io_in_1_bits_tag,
  input  logic             io_out_ready,
  output logic             io_out_valid,
  output logic [IDX_W-1:0] io_out_bits_idx,
  output logic [WAYS-1:0]  io_out_bits_way_en,
  output logic [TAG_W-1:0] io_out_bits_tag,
  output logic             io_out_chosen,
  output logic             io_busy
);

  typedef struct packed {
    logic [IDX_W-1:0] idx;
    logic [WAYS-1:0]  way_en;
    logic [TAG_W-1:0] tag;
  } entry_t;

  entry_t in0, in1, head0, head1, stage_q, stage_d;
  src_t   chosen_q, chosen_d, sel;
  logic   valid_q, valid_d;
  logic   empty0, empty1, full0, full1;
  logic   load, have, deq0, deq1;

  assign in0 = '{idx: io_in_0_bits_idx, way_en: io_in_0_bits_way_en, tag: io_in_0_bits_tag};
  assign in1 = '{idx: io_in_1_bits_idx, way_en: io_in_1_bits_way_en, tag: io_in_1_bits_tag};

  meta_write_fifo #(.DEPTH(DEPTH), .T(entry_t)) u_fifo0 (
    .clk_i(clock), .rst_i(reset), .flush_i(io_flush),
    .enq_valid_i(io_in_0_valid), .enq_ready_o(io_in_0_ready), .enq_data_i(in0),
    .deq_i(deq0), .deq_data_o(head0), .empty_o(empty0), .full_o(full0)
  );

  meta_write_fifo #(.DEPTH(DEPTH), .T(entry_t)) u_fifo1 (
    .clk_i(clock), .rst_i(reset), .flush_i(io_flush),
    .enq_valid_i(io_in_1_valid), .enq_ready_o(io_in_1_ready), .enq_data_i(in1),
    .deq_i(deq1), .deq_data_o(head1), .empty_o(empty1), .full_o(full1)
  );

  assign load = !valid_q || io_out_ready;
  assign have = !empty0 || !empty1;
  assign deq0 = load && have && (sel == SRC_P0) && !io_flush;
  assign deq1 = load && have && (sel == SRC_P1) && !io_flush;

`ifdef META_SCHED_STARVE_GUARD_EN
  localparam int unsigned WAIT_W = $clog2(STARVE_LIMIT + 1);

  logic [WAIT_W-1:0] wait_q, wait_d;
  logic              starved;

  assign starved = (wait_q == WAIT_W'(STARVE_LIMIT));

  always_comb begin
    sel = SRC_P0;
    if (!empty1 && (empty0 || starved)) sel = SRC_P1;
  end

  // Counts loads that bypassed a waiting port-1 entry; saturates at the limit.
  always_comb begin
    wait_d = wait_q;
    if (io_flush || empty1) begin
      wait_d = '0;
    end else if (load && have) begin
      if (sel == SRC_P1)  wait_d = '0;
      else if (!starved)  wait_d = wait_q + WAIT_W'(1);
    end
  end

  always_ff @(posedge clock) begin
    if (reset) wait_q <= '0;
    else       wait_q <= wait_d;
  end
`else
  always_comb begin
    sel = SRC_P0;
    if (empty0) sel = SRC_P1;
  end
`endif

  always_comb begin
    valid_d  = valid_q;
    stage_d  = stage_q;
    chosen_d = chosen_q;
    if (io_flush) begin
      valid_d = 1'b0;
    end else if (load) begin
      valid_d = have;
      if (have) begin
        stage_d  = (sel == SRC_P1) ? head1 : head0;
        chosen_d = sel;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      valid_q  <= 1'b0;
      stage_q  <= '0;
      chosen_q <= SRC_P0;
    end else begin
      valid_q  <= valid_d;
      stage_q  <= stage_d;
      chosen_q <= chosen_d;
    end
  end

  assign io_out_valid       = valid_q;
  assign io_out_bits_idx    = stage_q.idx;
  assign io_out_bits_way_en = stage_q.way_en;
  assign io_out_bits_tag    = stage_q.tag;
  assign io_out_chosen      = chosen_q;
  assign io_busy            = have || valid_q;

endmodule
